mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7: per-channel byte address width.
REQ-002 Parameter DATA_W, default 8: per-channel data width.
REQ-003 Parameter TIMEOUT, default 255: max BUSY cycles awaiting mem_ack before abort; range 1..255.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 M_oe_ram  input  2  per-channel read request; bit i = channel i.
REQ-007 M_we_ram  input  2  per-channel write request.
REQ-008 M_addr_ram  input  2*ADDR_W  channel i address in bits [i*ADDR_W +: ADDR_W].
REQ-009 M_Wdata_ram  input  2*DATA_W  channel i write data, same slicing.
REQ-010 M_data_ram_size  input  8  channel i access size in bits, in nibble [i*4 +: 4].
REQ-011 M_Rdata_ram  output  2*DATA_W  channel i read data, same slicing.
REQ-012 M_DataRdy  output  2  per-channel one-cycle completion pulse.
REQ-013 mem_oe / mem_we  output  1 each  shared-port read/write strobes.
REQ-014 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_size  output  4.
REQ-015 mem_rdata  input  DATA_W; mem_ack  input  1  shared-port completion, valid in the same cycle.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, BUSY, RESP.
REQ-018 IDLE: if any channel has oe|we=1, select grant g, latch g's oe/we/addr/wdata/size into request registers, and go to BUSY; otherwise remain in IDLE.
REQ-019 BUSY: drive mem_* from the latched request; on mem_ack=1, capture mem_rdata (reads) or 0 (writes) into the channel-g rdata register, then go to RESP.
REQ-020 BUSY: a cycle counter increments each BUSY cycle; when it reaches TIMEOUT without mem_ack, force rdata to 0, set err, and go to RESP.
REQ-021 RESP: M_DataRdy[g]=1 for exactly one cycle, then go to IDLE; mem_oe and mem_we are 0 in this state.
REQ-022 mem_oe and mem_we are 0 outside BUSY; M_DataRdy is 0 outside RESP.
REQ-023 Minimum turnaround: request seen in IDLE cycle N, mem_ack in cycle N+1, M_DataRdy[g] in cycle N+2, next request sampled in cycle N+3.
REQ-024 M_Rdata_ram slice g holds its captured value until the next completion on channel g; the other slice is unaffected.
REQ-025 Channel inputs are ignored outside IDLE; masters hold requests stable until M_DataRdy.
REQ-026 Channel with oe=1 and we=1 together in IDLE: err set, channel not granted, no M_DataRdy for it.
REQ-027 Grant policy when both channels request at once: see Configuration; a single requester is always granted.
REQ-028 last_grant register records g at each RESP.

Reset
REQ-029 Synchronous reset: state to IDLE; M_DataRdy, mem_oe, mem_we, err, the BUSY counter, M_Rdata_ram and latched request registers to 0; last_grant to 1.
REQ-030 Reset asserted in BUSY or RESP aborts the transaction; no M_DataRdy pulse is produced afterwards.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests are granted to the channel != last_grant.
REQ-032 Macro ARB_ROUND_ROBIN_EN undefined: channel 0 always wins simultaneous requests, and last_grant is unused.

Verification
REQ-033 Ch0 read addr 5, memory returns 0xA7 with ack in first BUSY cycle -> mem_oe=1 with mem_addr=5 in cycle N+1; M_DataRdy=01 in cycle N+2; M_Rdata_ram[7:0]=0xA7.
REQ-034 Both channels write continuously (ch0 0x11@3, ch1 0x22@4) with ARB_ROUND_ROBIN_EN -> grants 0,1,0,1; without the macro -> ch0 starves ch1.
REQ-035 mem_ack held 0 with TIMEOUT=4 -> 4 BUSY cycles, then M_DataRdy pulse with rdata 0 and err=1.
REQ-036 Ch1 oe=we=1 -> err=1, no mem strobe, M_DataRdy[1] stays 0.
REQ-037 Reset raised in BUSY -> next cycle IDLE, all outputs 0, no M_DataRdy.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-channel arbiter onto a single shared memory port.
// A granted request is latched in IDLE, presented on mem_* during BUSY until
// mem_ack or timeout, and completed with a one-cycle M_DataRdy pulse in RESP.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests); when undefined, channel 0 has fixed priority.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   M_oe_ram, M_we_ram  - per-channel read/write requests
//   M_addr_ram, M_Wdata_ram, M_data_ram_size - per-channel request payload
//   M_Rdata_ram, M_DataRdy - per-channel read data and completion pulse
//   mem_oe, mem_we, mem_addr, mem_wdata, mem_size - shared port request
//   mem_rdata, mem_ack  - shared port response
//   err                 - sticky error (illegal oe+we request or timeout)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          M_oe_ram,
  input  logic [1:0]          M_we_ram,
  input  logic [2*ADDR_W-1:0] M_addr_ram,
  input  logic [2*DATA_W-1:0] M_Wdata_ram,
  input  logic [7:0]          M_data_ram_size,
  output logic [2*DATA_W-1:0] M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
  output logic                mem_oe,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [3:0]          mem_size,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              gnt_q;
  logic [DATA_W-1:0] rdata_q [2];

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant_q;
`endif

  logic [1:0]        req_valid_c;
  logic              conflict_c;
  logic              grant_c;
  logic              timeout_c;
  logic              done_c;

  // A channel is a legal requester only with exactly one of oe/we set
  assign req_valid_c = (M_oe_ram | M_we_ram) & ~(M_oe_ram & M_we_ram);
  assign conflict_c  = |(M_oe_ram & M_we_ram);

  // Grant selection among legal requesters
  always_comb begin
    grant_c = 1'b0;
    if (req_valid_c == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_c = ~last_grant_q;
`else
      grant_c = 1'b0;
`endif
    end else if (req_valid_c[1]) begin
      grant_c = 1'b1;
    end
  end

  // Timeout fires on the TIMEOUT-th BUSY cycle; an ack in that cycle wins
  assign timeout_c = (state_q == S_BUSY) && !mem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done_c    = (state_q == S_BUSY) && (mem_ack || timeout_c);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_valid_c) state_d = S_BUSY;
      S_BUSY:  if (done_c)       state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request latch, shared-port strobes, completion and error tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      M_DataRdy  <= 2'b00;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= '0;
      err        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          M_DataRdy <= 2'b00;
          if (conflict_c) err <= 1'b1;
          if (|req_valid_c) begin
            gnt_q     <= grant_c;
            cnt_q     <= '0;
            mem_oe    <= M_oe_ram[grant_c];
            mem_we    <= M_we_ram[grant_c];
            mem_addr  <= grant_c ? M_addr_ram[2*ADDR_W-1:ADDR_W]
                                 : M_addr_ram[ADDR_W-1:0];
            mem_wdata <= grant_c ? M_Wdata_ram[2*DATA_W-1:DATA_W]
                                 : M_Wdata_ram[DATA_W-1:0];
            mem_size  <= grant_c ? M_data_ram_size[7:4]
                                 : M_data_ram_size[3:0];
          end
        end
        S_BUSY: begin
          if (done_c) begin
            // Writes and timeouts both return zero data
            rdata_q[gnt_q] <= (mem_ack && mem_oe) ? mem_rdata : '0;
            if (timeout_c) err <= 1'b1;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            M_DataRdy <= gnt_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          M_DataRdy <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_q <= gnt_q;
`endif
        end
        default: begin
          M_DataRdy <= 2'b00;
          mem_oe    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

  assign M_Rdata_ram = {rdata_q[1], rdata_q[0]};

endmodule
